// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and defaults for the fetch PC redirect controller.
package pc_redirect_ctrl_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int BOOT_ADDR_DEF = 256;
    localparam int EPOCH_W_DEF   = 2;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef logic [EPOCH_W_DEF-1:0] epoch_t;

endpackage

// File: rtl/pc_redirect_ctrl_slot.sv
// One pending-redirect slot: valid bit plus target and optional tag.
// A load in the same cycle as a clear wins, leaving the slot valid with new contents.
module redir_slot #(
    parameter int AW = 32,
    parameter int TW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          clr,
    input  logic [AW-1:0] load_addr,
    input  logic [TW-1:0] load_tag,
    output logic          vld,
    output logic [AW-1:0] addr,
    output logic [TW-1:0] tag
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= 1'b1;
        end else if (clr) begin
            vld <= 1'b0;
        end
    end

    // Contents are only observed while vld is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            addr <= load_addr;
            tag  <= load_tag;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Prioritises branch redirects over BPU predictions, holds them across stalls,
// issues the boot vector after reset and tracks the fetch epoch.
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int BOOT_ADDR = BOOT_ADDR_DEF,
    parameter int EPOCH_W   = EPOCH_W_DEF,
    parameter int DROP_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic [XLEN-1:0]    cur_pc,
    input  logic               br,
    input  logic [XLEN-1:0]    br_addr,
    input  logic               pr,
    input  logic [XLEN-1:0]    pr_addr,
    input  logic [XLEN-1:0]    pr_pc,
    output logic               redir_o,
    output logic [XLEN-1:0]    redir_addr_o,
    output logic [EPOCH_W-1:0] epoch_o,
    output logic               busy_o,
    output logic [DROP_W-1:0]  drop_cnt_o
);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t          state, state_nx;
    logic            bv, pv;
    logic [XLEN-1:0] ba, pa, pt;
    logic            br_tag_unused;

    logic run, br_ld, pr_ld, pt_hit, br_cons, pr_cons, pr_stale;

    assign run      = (state != BOOT);
    assign br_ld    = run & br;
    assign pr_ld    = run & pr & ~br & ~bv;
    assign pt_hit   = pv & (pt == cur_pc);
    assign br_cons  = bv & ~stall;
    assign pr_cons  = ~bv & pt_hit & ~stall;
    assign pr_stale = pv & ~bv & (pt != cur_pc) & ~stall;

    redir_slot #(.AW(XLEN), .TW(1)) u_br_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (br_ld),
        .clr       (br_cons),
        .load_addr (br_addr),
        .load_tag  (1'b0),
        .vld       (bv),
        .addr      (ba),
        .tag       (br_tag_unused)
    );

    // A new branch squashes whatever prediction was waiting.
    redir_slot #(.AW(XLEN), .TW(XLEN)) u_pr_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (pr_ld),
        .clr       (br_ld | pr_cons | pr_stale),
        .load_addr (pr_addr),
        .load_tag  (pr_pc),
        .vld       (pv),
        .addr      (pa),
        .tag       (pt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BOOT;
            epoch_o    <= '0;
            drop_cnt_o <= '0;
        end else begin
            state <= state_nx;
            if (br_ld) begin
                epoch_o <= epoch_o + 1'b1;
            end
            if (pr_stale) begin
                drop_cnt_o <= sat_inc(drop_cnt_o);
            end
        end
    end

    always_comb begin
        state_nx     = state;
        redir_o      = 1'b0;
        redir_addr_o = bv ? ba : pa;
        busy_o       = 1'b0;
        case (state)
            BOOT: begin
                redir_o      = 1'b1;
                redir_addr_o = XLEN'(BOOT_ADDR);
                if (!stall) state_nx = RUN;
            end
            RUN: begin
                redir_o = bv | pt_hit;
                if ((bv | pv) & stall) state_nx = HOLD;
            end
            HOLD: begin
                redir_o = bv | pt_hit;
                busy_o  = 1'b1;
                if (!stall) state_nx = RUN;
            end
            default: begin
                state_nx = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b1;
    logic [31:0] cur_pc = '0;
    logic        br = 1'b0;
    logic [31:0] br_addr = '0;
    logic        pr = 1'b0;
    logic [31:0] pr_addr = '0;
    logic [31:0] pr_pc = '0;
    logic        redir_o;
    logic [31:0] redir_addr_o;
    logic [1:0]  epoch_o;
    logic        busy_o;
    logic [7:0]  drop_cnt_o;

    int checks = 0;
    int errors = 0;

    pc_redirect_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .cur_pc       (cur_pc),
        .br           (br),
        .br_addr      (br_addr),
        .pr           (pr),
        .pr_addr      (pr_addr),
        .pr_pc        (pr_pc),
        .redir_o      (redir_o),
        .redir_addr_o (redir_addr_o),
        .epoch_o      (epoch_o),
        .busy_o       (busy_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 clk = ~clk;

    // Behavioural model: boot flag, hold flag, two pending redirects, epoch and drop counter.
    bit          m_boot, m_hold, m_bv, m_pv;
    logic [31:0] m_ba, m_pa, m_pt;
    int          m_epoch, m_drop;

    function automatic void model_reset();
        m_boot = 1; m_hold = 0; m_bv = 0; m_pv = 0;
        m_epoch = 0; m_drop = 0;
    endfunction

    function automatic void model_step();
        bit nbv, npv, nh;
        if (!rst) begin
            model_reset();
            return;
        end
        if (m_boot) begin
            if (!stall) m_boot = 0;
            return;
        end
        nh  = m_hold ? stall : ((m_bv || m_pv) && stall);
        nbv = m_bv;
        npv = m_pv;
        if (!stall) begin
            if (m_bv) nbv = 0;
            else if (m_pv) begin
                if (m_pt != cur_pc) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                npv = 0;
            end
        end
        if (br) begin
            nbv = 1; m_ba = br_addr; m_epoch = (m_epoch + 1) % 4; npv = 0;
        end else if (pr && !m_bv) begin
            npv = 1; m_pa = pr_addr; m_pt = pr_pc;
        end
        m_bv = nbv; m_pv = npv; m_hold = nh;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: advance the model over the previous edge, drive new inputs, compare.
    task automatic cycle(input logic r, input logic s, input logic b, input logic [31:0] badr,
                         input logic p, input logic [31:0] padr, input logic [31:0] ppc,
                         input logic [31:0] cpc);
        bit          e_redir;
        logic [31:0] e_addr;
        model_step();
        @(negedge clk);
        rst = r; stall = s; br = b; br_addr = badr;
        pr = p; pr_addr = padr; pr_pc = ppc; cur_pc = cpc;
        #1;
        if (!rst) model_reset();
        if (m_boot) begin
            e_redir = 1; e_addr = 32'd256;
        end else begin
            e_redir = m_bv || (m_pv && m_pt == cur_pc);
            e_addr  = m_bv ? m_ba : m_pa;
        end
        cmp("redir", {31'd0, redir_o}, {31'd0, e_redir});
        if (e_redir) cmp("redir_addr", redir_addr_o, e_addr);
        cmp("epoch", {30'd0, epoch_o}, m_epoch);
        cmp("busy", {31'd0, busy_o}, {31'd0, (!m_boot && m_hold)});
        cmp("drop_cnt", {24'd0, drop_cnt_o}, m_drop);
    endtask

    task automatic idle(input logic s, input logic [31:0] cpc);
        cycle(1'b1, s, 1'b0, '0, 1'b0, '0, '0, cpc);
    endtask

    initial begin
        model_reset();
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
        cmp("lit_reset_redir", {31'd0, redir_o}, 32'd1);
        cmp("lit_reset_addr", redir_addr_o, 32'd256);

        // Boot vector held through a stalled reset release.
        for (int i = 0; i < 3; i++) begin
            idle(1'b1, '0);
            cmp("lit_boot_addr", redir_addr_o, 32'd256);
        end
        idle(1'b0, '0);
        idle(1'b0, '0);
        cmp("lit_run_redir", {31'd0, redir_o}, 32'd0);

        // Unstalled branch.
        cycle(1'b1, 1'b0, 1'b1, 32'h1000, 1'b0, '0, '0, '0);
        idle(1'b0, '0);
        cmp("lit_br_addr", redir_addr_o, 32'h1000);
        cmp("lit_br_epoch", {30'd0, epoch_o}, 32'd1);
        idle(1'b0, '0);
        cmp("lit_br_cleared", {31'd0, redir_o}, 32'd0);

        // Branch held across five stalled cycles.
        cycle(1'b1, 1'b1, 1'b1, 32'h2000, 1'b0, '0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            idle(1'b1, '0);
            cmp("lit_hold_addr", redir_addr_o, 32'h2000);
            if (i > 0) cmp("lit_hold_busy", {31'd0, busy_o}, 32'd1);
        end
        idle(1'b0, '0);
        cmp("lit_release_addr", redir_addr_o, 32'h2000);
        idle(1'b0, '0);
        cmp("lit_released", {31'd0, redir_o}, 32'd0);

        // Stale prediction dropped.
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h5000, 32'h300, 32'h300);
        idle(1'b1, 32'h304);
        idle(1'b0, 32'h304);
        idle(1'b0, 32'h304);
        cmp("lit_drop_cnt", {24'd0, drop_cnt_o}, 32'd1);
        cmp("lit_drop_noredir", {31'd0, redir_o}, 32'd0);

        // Matching prediction delivered.
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h6000, 32'h400, 32'h3f0);
        idle(1'b0, 32'h400);
        cmp("lit_pred_redir", {31'd0, redir_o}, 32'd1);
        cmp("lit_pred_addr", redir_addr_o, 32'h6000);

        // Branch beats a same-cycle prediction and blocks later ones.
        cycle(1'b1, 1'b1, 1'b1, 32'h7000, 1'b1, 32'h8000, 32'h500, 32'h500);
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b1, 32'h9000, 32'h500, 32'h500);
        cmp("lit_brpr_addr", redir_addr_o, 32'h7000);
        idle(1'b0, 32'h500);
        idle(1'b0, 32'h500);
        cmp("lit_brpr_empty", {31'd0, redir_o}, 32'd0);

        // Epoch wrap across four pulses.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 32'h100 + 32'(i), 1'b0, '0, '0, '0);
            if (i == 1) cmp("lit_epoch_wrap", {30'd0, epoch_o}, 32'd0);
        end
        idle(1'b0, '0);

        // Asynchronous reset while holding a branch.
        cycle(1'b1, 1'b1, 1'b1, 32'hA000, 1'b0, '0, '0, '0);
        idle(1'b1, '0);
        idle(1'b1, '0);
        cmp("lit_pre_rst_busy", {31'd0, busy_o}, 32'd1);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
        cmp("lit_rst_addr", redir_addr_o, 32'd256);
        cmp("lit_rst_busy", {31'd0, busy_o}, 32'd0);
        cmp("lit_rst_epoch", {30'd0, epoch_o}, 32'd0);
        idle(1'b1, '0);
        idle(1'b0, '0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        r, s, b, p;
            logic [31:0] cpc, ppc;
            r   = ($urandom_range(0, 199) != 0);
            s   = ($urandom_range(0, 99) < 40);
            b   = ($urandom_range(0, 99) < 10);
            p   = ($urandom_range(0, 99) < 35);
            cpc = 32'h100 + 32'($urandom_range(0, 3)) * 4;
            ppc = 32'h100 + 32'($urandom_range(0, 3)) * 4;
            cycle(r, s, b, $urandom, p, $urandom, ppc, cpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
